pp_accumulator: RTL

PP_ACCUMULATOR -- requirements
Module: pp_accumulator

---
 rtl/pp_accumulator_pkg.sv | 14 +
 rtl/pp_shift_align.sv | 31 +++
 rtl/pp_accumulator.sv | 112 +++++++++++
 3 files changed

// File: rtl/pp_accumulator_pkg.sv
// Shared defaults and FSM state type for the partial-product accumulator.
package pp_accumulator_pkg;

  localparam int PP_W_DEF    = 77;
  localparam int ACC_W_DEF   = 256;
  localparam int SHIFT_W_DEF = 8;
  localparam int CNT_W_DEF   = 8;

  typedef enum logic {
    IDLE,
    ACCUM
  } state_t;

endpackage

// File: rtl/pp_shift_align.sv
// Barrel-shifts a partial product into accumulator alignment and flags lost high bits.
// Lost-bit detection only exists when PP_ACC_CARRY_DET_EN is defined.
module pp_shift_align #(
  parameter int PP_W    = 77,
  parameter int ACC_W   = 256,
  parameter int SHIFT_W = 8
) (
  input  logic [PP_W-1:0]    pp,
  input  logic [SHIFT_W-1:0] shift,
  output logic [ACC_W-1:0]   term,
  output logic               lost
);

`ifdef PP_ACC_CARRY_DET_EN
  // Wide enough that no bit of pp can fall off the top for any shift amount.
  localparam int WIDE_W = ACC_W + PP_W + (1 << SHIFT_W);

  logic [WIDE_W-1:0] wide;

  assign wide = {{(WIDE_W-PP_W){1'b0}}, pp} << shift;
  assign term = wide[ACC_W-1:0];
  assign lost = |wide[WIDE_W-1:ACC_W];
`else
  logic [ACC_W-1:0] ext;

  assign ext  = ACC_W'(pp);
  assign term = ext << shift;
  assign lost = 1'b0;
`endif

endmodule

// File: rtl/pp_accumulator.sv
// Sums shifted multiplier partial products into one wide result per product.
// Optional carry/truncation detection: define PP_ACC_CARRY_DET_EN.
module pp_accumulator
  import pp_accumulator_pkg::*;
#(
  parameter int PP_W    = PP_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SHIFT_W = SHIFT_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [PP_W-1:0]    in_pp,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_first,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic [CNT_W-1:0]   out_tiles,
  output logic               drop,
  output logic               carry,
  input  logic               clr
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] term;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic [CNT_W-1:0] cnt_next;
  logic             lost;
  logic             restart;
  logic             load;
  logic             can_load;

  pp_shift_align #(
    .PP_W   (PP_W),
    .ACC_W  (ACC_W),
    .SHIFT_W(SHIFT_W)
  ) u_align (
    .pp   (in_pp),
    .shift(in_shift),
    .term (term),
    .lost (lost)
  );

  // A tile in IDLE, or any tile flagged first, starts a fresh sum.
  assign restart  = (state == IDLE) || in_first;
  assign base     = restart ? '0 : acc;
  assign cnt_next = restart ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + 1'b1);
  assign load     = in_valid && in_last;
  assign can_load = !out_valid || out_ready;

`ifdef PP_ACC_CARRY_DET_EN
  logic add_carry;
  logic carry_set;

  assign {add_carry, sum} = {1'b0, base} + {1'b0, term};
  assign carry_set        = in_valid && (add_carry || lost);
`else
  assign sum   = base + term;
  // lost is constant 0 in this build, so carry is tied low.
  assign carry = lost;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tiles <= '0;
      drop      <= 1'b0;
`ifdef PP_ACC_CARRY_DET_EN
      carry     <= 1'b0;
`endif
    end else begin
      if (in_valid) begin
        acc   <= sum;
        cnt   <= cnt_next;
        state <= in_last ? IDLE : ACCUM;
      end

      if (load && can_load) begin
        out_valid <= 1'b1;
        out_data  <= sum;
        out_tiles <= cnt_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (load && !can_load) begin
        drop <= 1'b1;
      end else if (clr) begin
        drop <= 1'b0;
      end

`ifdef PP_ACC_CARRY_DET_EN
      if (carry_set) begin
        carry <= 1'b1;
      end else if (clr) begin
        carry <= 1'b0;
      end
`endif
    end
  end

endmodule
